// File: rtl/fft_bitrev_buffer.sv
// Single-frame FFT reorder buffer: collects N samples in natural order, then drains them natural or bit-reversed.
// Latency: first output the cycle after the last input; in_ready drops for the whole drain, out_* hold while out_ready is low.
module fft_bitrev_buffer #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     bitrev_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [LOG2N-1:0]         wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0]         rd_cnt_q, rd_cnt_d;
    logic                     mode_q, mode_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;
    logic [LOG2N-1:0]         out_idx_q, out_idx_d;

    logic signed [DATA_W-1:0] mem_re_q [N];
    logic signed [DATA_W-1:0] mem_im_q [N];

    logic             in_hs, out_hs, wr_en, load_en;
    logic [LOG2N-1:0] load_r, rd_addr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_ready  = (state_q != DRAIN);
    assign busy      = (state_q != IDLE);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        wr_en       = 1'b0;
        load_en     = 1'b0;
        load_r      = '0;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    mode_d   = bitrev_en;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (in_hs) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d    = '0;
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        load_en     = 1'b1;
                        load_r      = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d    = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        load_en  = 1'b1;
                        load_r   = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Address 0 reads the same in either order, so the first load needs no special mode handling.
        rd_addr = mode_q ? bitrev(load_r) : load_r;
        if (load_en) begin
            out_re_d   = mem_re_q[rd_addr];
            out_im_d   = mem_im_q[rd_addr];
            out_idx_d  = rd_addr;
            out_last_d = (load_r == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Storage is never cleared; the counters guarantee every read slot was written in the current frame.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_re_q[wr_cnt_q] <= in_re;
            mem_im_q[wr_cnt_q] <= in_im;
        end
    end
endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: table of frame scenarios feeding an expected-output queue, plus a
// negedge monitor that tracks handshakes and checks ready/valid/busy, output data and stall stability.
module tb_fft_bitrev_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        bitrev_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fft_bitrev_buffer #(.DATA_W(16), .LOG2N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .bitrev_en(bitrev_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    typedef struct {
        string       name;
        bit          mode;
        bit          toggle;
        int          pat;
        int          stall_r;
        int          gap_pct;
        bit          hold_valid;
        logic [63:0] exp_idx;
    } vec_t;

    exp_t exp_q[$];

    int   m_wcnt  = 0;
    bit   m_drain = 1'b0;
    bit   prev_stall = 1'b0;
    exp_t held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat_re(input int pat, input int k);
        case (pat)
            0:       return 16'(k);
            1:       return (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
            default: return 16'h0100 + 16'(k);
        endcase
    endfunction

    function automatic logic [15:0] pat_im(input int pat, input int k);
        case (pat)
            0:       return 16'(0 - k);
            1:       return (k % 2 == 1) ? 16'h7FFF : 16'h8000;
            default: return 16'hA500 ^ 16'(k);
        endcase
    endfunction

    // Model: decides at each negedge what the next rising edge will do.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            m_wcnt     = 0;
            m_drain    = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            exp_t cur;
            bit   exp_ir;
            exp_ir = !m_drain;
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(m_drain));
            chk("busy", 32'(busy), 32'(m_drain || m_wcnt != 0));
            cur = '{re: out_re, im: out_im, idx: out_idx, last: out_last};
            if (out_valid && !out_ready) begin
                if (prev_stall) chk("stall_stable", 32'(cur), 32'(held));
                held       = cur;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_idx), 32'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_re", 32'(out_re), 32'(e.re));
                    chk("out_im", 32'(out_im), 32'(e.im));
                    chk("out_idx", 32'(out_idx), 32'(e.idx));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) m_drain = 1'b0;
                end
            end
            if (in_valid && exp_ir) begin
                m_wcnt++;
                if (m_wcnt == 16) begin
                    m_wcnt  = 0;
                    m_drain = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n samples of a frame; returns at #1 after the edge accepting the last one.
    task automatic feed(input vec_t v, input int n, output bit ok);
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            int guard;
            bit acc;
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                in_valid  = ($urandom_range(0, 99) >= v.gap_pct);
                in_re     = pat_re(v.pat, k);
                in_im     = pat_im(v.pat, k);
                bitrev_en = v.mode ^ (v.toggle && (k % 2 == 1));
                @(negedge clk);
                acc = in_valid && in_ready;
                tick();
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'(k), 32'hFFFF);
                ok = 1'b0;
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int guard;
        guard = 0;
        while ((m_drain || exp_q.size() != 0) && guard < 200) begin
            if (out_valid && out_last) in_valid = 1'b0;
            tick();
            guard++;
        end
        if (guard >= 200) chk({nm, "_drain_timeout"}, 32'(exp_q.size()), 32'h0);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        bit ok;
        for (int r = 0; r < 16; r++) begin
            int a;
            a = int'(v.exp_idx[4*r +: 4]);
            exp_q.push_back('{re: pat_re(v.pat, a), im: pat_im(v.pat, a),
                              idx: 4'(a), last: (r == 15)});
        end
        feed(v, 16, ok);
        if (!ok) return;
        in_valid = v.hold_valid;
        in_re    = 16'h5A5A;
        in_im    = 16'hA5A5;
        if (v.stall_r >= 0) begin
            repeat (v.stall_r) tick();
            chk({v.name, "_stall_re"}, 32'(out_re), 32'(pat_re(v.pat, int'(v.exp_idx[4*v.stall_r +: 4]))));
            out_ready = 1'b0;
            repeat (5) tick();
            out_ready = 1'b1;
        end
        wait_idle(v.name);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({nm, "_out_last"}, 32'(out_last), 32'h0);
        chk({nm, "_out_re"}, 32'(out_re), 32'h0);
        chk({nm, "_out_im"}, 32'(out_im), 32'h0);
        chk({nm, "_out_idx"}, 32'(out_idx), 32'h0);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    localparam logic [63:0] NAT = 64'hFEDCBA9876543210;
    localparam logic [63:0] REV = 64'hF7B3D591E6A2C480;

    initial begin
        vec_t vecs[6];
        vec_t rv;
        bit   ok;
        vecs[0] = '{name: "bitrev",  mode: 1, toggle: 0, pat: 0, stall_r: -1, gap_pct: 0,  hold_valid: 0, exp_idx: REV};
        vecs[1] = '{name: "natural", mode: 0, toggle: 1, pat: 0, stall_r: -1, gap_pct: 0,  hold_valid: 0, exp_idx: NAT};
        vecs[2] = '{name: "stall",   mode: 1, toggle: 0, pat: 0, stall_r: 2,  gap_pct: 0,  hold_valid: 0, exp_idx: REV};
        vecs[3] = '{name: "gaps",    mode: 0, toggle: 0, pat: 2, stall_r: -1, gap_pct: 40, hold_valid: 1, exp_idx: NAT};
        vecs[4] = '{name: "ext_a",   mode: 1, toggle: 0, pat: 1, stall_r: -1, gap_pct: 0,  hold_valid: 0, exp_idx: REV};
        vecs[5] = '{name: "ext_b",   mode: 0, toggle: 0, pat: 1, stall_r: -1, gap_pct: 0,  hold_valid: 0, exp_idx: NAT};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_state("por");

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Abort a frame after 7 accepts, then prove the next frame is clean.
        rv = '{name: "after_rst", mode: 1, toggle: 0, pat: 2, stall_r: -1, gap_pct: 0, hold_valid: 0, exp_idx: REV};
        feed(vecs[0], 7, ok);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_state("midrst");
        run_frame(rv);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_bitrev_buffer.md
FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

Interface
REQ-001 Parameter: DATA_W, default 16, width of each signed real/imaginary component.
REQ-002 Parameter: LOG2N, default 4, log2 of frame length N = 2^LOG2N; legal range 1..10.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input sample valid.
REQ-006 in_ready  output  1  buffer can accept a sample.
REQ-007 in_re, in_im  input  DATA_W each  signed input sample, natural order.
REQ-008 bitrev_en  input  1  order mode: 1 = bit-reversed output, 0 = natural output.
REQ-009 out_valid  output  1  output sample valid.
REQ-010 out_ready  input  1  downstream accepts sample.
REQ-011 out_re, out_im  output  DATA_W each  signed output sample.
REQ-012 out_idx  output  LOG2N  natural-order buffer address of the current output sample.
REQ-013 out_last  output  1  marks sample N-1 of the output frame.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, FILL, DRAIN.
REQ-016 Input handshake SHALL be in_valid && in_ready at a rising edge; output handshake SHALL be out_valid && out_ready.
REQ-017 in_ready SHALL be decoded from state only: 1 in IDLE/FILL, 0 in DRAIN; it SHALL NOT depend on in_valid.
REQ-018 Sample k of a frame (k = count of accepted handshakes, 0..N-1) SHALL be stored at address k; data is passed unmodified (no scaling, rounding or saturation).
REQ-019 IDLE -> FILL on the first input handshake; bitrev_en SHALL be captured at that edge and held for the whole frame.
REQ-020 On the edge accepting sample N-1, the FSM SHALL enter DRAIN and the output register SHALL load address 0 with out_valid <= 1 (first output visible the cycle after the last input).
REQ-021 For output count r = 0..N-1, the read address SHALL be bitrev(r) over LOG2N bits if the captured mode is 1, else r; out_idx SHALL equal that address.
REQ-022 Each output handshake SHALL load the sample for r+1 into out_re/out_im/out_idx/out_last in the same edge (no bubble under continuous out_ready).
REQ-023 While out_valid && !out_ready, all out_* SHALL remain stable.
REQ-024 out_last SHALL be 1 only while presenting r = N-1.
REQ-025 On the handshake of r = N-1: out_valid <= 0, out_last <= 0, state <= IDLE; in_ready is 1 in the following cycle.
REQ-026 in_valid during DRAIN SHALL be ignored; no sample is written and counters are unaffected.
REQ-027 Write and read counters SHALL wrap to 0 at frame end; no partial frame is ever output.
REQ-028 Single buffer: a new frame SHALL NOT be accepted until the previous frame has fully drained.

Reset
REQ-029 When rst_n = 0 at an edge: state <= IDLE, write/read counters <= 0, out_valid/out_last <= 0, out_re/out_im/out_idx <= 0, captured mode <= 0; busy = 0 and in_ready = 1 after that edge.
REQ-030 Reset SHALL take effect from any state, including mid-FILL or mid-DRAIN, discarding the partial frame; sample storage need not be cleared and stale contents SHALL never appear on the output.

Verification (N = 16, DATA_W = 16)
REQ-031 Feed re = k, im = -k, k = 0..15 back-to-back, bitrev_en = 1, out_ready = 1 -> out_re = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_last only on 15; first out_valid one cycle after the 16th accept; 16 consecutive output cycles.
REQ-032 Same frame with bitrev_en = 0, toggled mid-frame -> out_re = 0..15 in natural order; the toggle has no effect.
REQ-033 Drop out_ready for 5 cycles while the 3rd output (value 4) is presented -> out_re = 4 and out_idx = 4 held stable; full sequence completes with no loss or duplication.
REQ-034 Random in_valid gaps, then hold in_valid = 1 throughout DRAIN -> only handshakes are counted; in_ready = 0 for the whole DRAIN; no extra sample is written.
REQ-035 Assert rst_n = 0 after 7 accepted samples -> all outputs return to reset values; the next full frame drains correctly with no stale data.
REQ-036 Two back-to-back frames using values 0x7FFF and 0x8000 -> values pass bit-exact; in_ready rises the cycle after the first frame's out_last handshake.
